// File: rtl/md4_gen_pkg.sv
// -----------------------------------------------------------------------------
// md4_gen_pkg
// Shared types and helpers for the triple-redundant MD4 candidate generator.
//   gen_state_e      : controller state (IDLE, RUN, DRAIN, DONE)
//   MD4_PIPE_LATENCY : default md4_pipe latency in cycles
//   vote3_bits       : generic bitwise 2-of-3 majority on a VOTE_MAX_W vector
//   vote3_state      : majority vote of three state copies
// Callers of vote3_bits widen their operands to VOTE_MAX_W and cast the result
// back to their own width, so any width up to VOTE_MAX_W can be voted.
// -----------------------------------------------------------------------------
package md4_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } gen_state_e;

    localparam int MD4_PIPE_LATENCY = 48;
    localparam int VOTE_MAX_W       = 64;

    function automatic logic [VOTE_MAX_W-1:0] vote3_bits(
        input logic [VOTE_MAX_W-1:0] a,
        input logic [VOTE_MAX_W-1:0] b,
        input logic [VOTE_MAX_W-1:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic gen_state_e vote3_state(
        input gen_state_e a,
        input gen_state_e b,
        input gen_state_e c
    );
        return gen_state_e'(2'(vote3_bits(VOTE_MAX_W'(a), VOTE_MAX_W'(b), VOTE_MAX_W'(c))));
    endfunction

endpackage

// File: rtl/cand_delay_line.sv
// -----------------------------------------------------------------------------
// cand_delay_line
// Fixed-depth shift register that re-aligns an issued candidate with the
// digest leaving the hash pipes. Shifts every cycle; rst_i clears every stage.
//   clk     : clock
//   rst_i   : synchronous active-high clear
//   data_i  : p_width-bit word entering stage 0
//   data_o  : word that entered p_depth cycles earlier
// -----------------------------------------------------------------------------
module cand_delay_line #(
    parameter int p_width = 33,
    parameter int p_depth = 48
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic [p_width-1:0] data_i,
    output logic [p_width-1:0] data_o
);

    logic [p_width-1:0] stage_q [p_depth];

    for (genvar gi = 0; gi < p_depth; gi++) begin : g_stage
        logic [p_width-1:0] stage_d;

        if (gi == 0) begin : g_head
            assign stage_d = data_i;
        end else begin : g_body
            assign stage_d = stage_q[gi-1];
        end

        always_ff @(posedge clk) begin
            if (rst_i) begin
                stage_q[gi] <= '0;
            end else begin
                stage_q[gi] <= stage_d;
            end
        end
    end

    assign data_o = stage_q[p_depth-1];

endmodule

// File: rtl/md4_candidate_gen_tmr.sv
// -----------------------------------------------------------------------------
// md4_candidate_gen_tmr
// Triple-redundant counter-based candidate source feeding three md4_pipe
// replicas. State, counter and remaining count are each held in three copies
// that are majority-voted and rewritten with the voted next value every cycle.
//   clk, rst              : clock, synchronous active-high reset
//   start/start_value/count: launch a run of `count` candidates from start_value
//   pause                 : holds issuing while high (RUN only)
//   inp_data_1/2/3        : candidate copies, one per pipe
//   issue_valid           : inp_data_* carry a freshly issued candidate
//   out_valid/out_value   : candidate aligned with the voted digest
//   busy, done            : run in progress / one-cycle end-of-run pulse
//   correctableError      : state copies disagreed on the previous cycle
// p_inp_data_len must not exceed VOTE_MAX_W; p_pipe_latency must be >= 1.
// -----------------------------------------------------------------------------
module md4_candidate_gen_tmr
    import md4_gen_pkg::*;
#(
    parameter int p_inp_data_len = 32,
    parameter int p_pipe_latency = MD4_PIPE_LATENCY
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [p_inp_data_len-1:0] start_value,
    input  logic [31:0]               count,
    input  logic                      pause,
    output logic [p_inp_data_len-1:0] inp_data_1,
    output logic [p_inp_data_len-1:0] inp_data_2,
    output logic [p_inp_data_len-1:0] inp_data_3,
    output logic                      issue_valid,
    output logic                      out_valid,
    output logic [p_inp_data_len-1:0] out_value,
    output logic                      busy,
    output logic                      done,
    output logic                      correctableError
);

    localparam int W = p_inp_data_len;

    gen_state_e     state_c [3];
    logic [W-1:0]   cnt_c   [3];
    logic [31:0]    rem_c   [3];
    logic [W-1:0]   inp_c   [3];

    gen_state_e     state_v, state_d;
    logic [W-1:0]   cnt_v,   cnt_d;
    logic [31:0]    rem_v,   rem_d;

    logic issue_d, inp_clear, busy_d, done_d, err_d;
    logic issue_q, busy_q, done_q, err_q;

    // Voted view of the three copies; everything downstream uses only this.
    assign state_v = vote3_state(state_c[0], state_c[1], state_c[2]);
    assign cnt_v   = W'(vote3_bits(VOTE_MAX_W'(cnt_c[0]), VOTE_MAX_W'(cnt_c[1]),
                                   VOTE_MAX_W'(cnt_c[2])));
    assign rem_v   = 32'(vote3_bits(VOTE_MAX_W'(rem_c[0]), VOTE_MAX_W'(rem_c[1]),
                                    VOTE_MAX_W'(rem_c[2])));

    // State register: three copies, all loaded from the single voted next value.
    for (genvar gi = 0; gi < 3; gi++) begin : g_copy
        gen_state_e   state_q;
        logic [W-1:0] cnt_q;
        logic [31:0]  rem_q;
        logic [W-1:0] inp_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                rem_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rem_q   <= rem_d;
            end
        end

        // Separate output register per pipe so one upset cannot hit all three.
        always_ff @(posedge clk) begin
            if (rst || inp_clear) begin
                inp_q <= '0;
            end else if (issue_d) begin
                inp_q <= cnt_v;
            end
        end

        assign state_c[gi] = state_q;
        assign cnt_c[gi]   = cnt_q;
        assign rem_c[gi]   = rem_q;
        assign inp_c[gi]   = inp_q;
    end

    // Next-state logic. In DRAIN the remaining-count copies are reused as the
    // drain counter, so the drain phase is protected by the same voting.
    always_comb begin
        state_d = state_v;
        cnt_d   = cnt_v;
        rem_d   = rem_v;
        unique case (state_v)
            ST_IDLE: begin
                if (start) begin
                    if (count != 32'd0) begin
                        state_d = ST_RUN;
                        cnt_d   = start_value;
                        rem_d   = count;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (!pause) begin
                    cnt_d = cnt_v + W'(1);
                    if (rem_v <= 32'd1) begin
                        state_d = ST_DRAIN;
                        rem_d   = 32'(p_pipe_latency);
                    end else begin
                        rem_d = rem_v - 32'd1;
                    end
                end
            end
            ST_DRAIN: begin
                // Exits one cycle after the count reaches 1 so that DRAIN lasts
                // exactly p_pipe_latency cycles after the last issue.
                rem_d = rem_v - 32'd1;
                if (rem_v <= 32'd1) begin
                    state_d = ST_DONE;
                    rem_d   = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic. done is the registered image of the DONE state, so it
    // trails the state by one cycle; busy covers that extra cycle after DRAIN.
    always_comb begin
        issue_d   = (state_v == ST_RUN) && !pause;
        inp_clear = (state_v == ST_DONE);
        busy_d    = (state_d == ST_RUN) || (state_d == ST_DRAIN) ||
                    ((state_v == ST_DRAIN) && (state_d == ST_DONE));
        done_d    = (state_v == ST_DONE);
        err_d     = (state_c[0] != state_c[1]) || (state_c[0] != state_c[2]) ||
                    (cnt_c[0]   != cnt_c[1])   || (cnt_c[0]   != cnt_c[2])   ||
                    (rem_c[0]   != rem_c[1])   || (rem_c[0]   != rem_c[2]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            issue_q <= issue_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    cand_delay_line #(
        .p_width (W + 1),
        .p_depth (p_pipe_latency)
    ) u_delay (
        .clk    (clk),
        .rst_i  (rst),
        .data_i ({issue_q, inp_c[0]}),
        .data_o ({out_valid, out_value})
    );

    assign inp_data_1       = inp_c[0];
    assign inp_data_2       = inp_c[1];
    assign inp_data_3       = inp_c[2];
    assign issue_valid      = issue_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign correctableError = err_q;

endmodule
